// File: rtl/rps_input_frontend_if.sv
// Pushbutton-to-GameController bundle for the rock/paper/scissors input
// front end: raw bouncing buttons in, clean held choice and lock pulse out.
interface rps_input_frontend_if;
  logic raw_rock;
  logic raw_paper;
  logic raw_scissors;
  logic raw_lock;
  logic rock_button;
  logic paper_button;
  logic scissors_button;
  logic stop_signal;
  logic locked;

  modport master (
    output raw_rock, raw_paper, raw_scissors, raw_lock,
    input  rock_button, paper_button, scissors_button, stop_signal, locked
  );

  modport slave (
    input  raw_rock, raw_paper, raw_scissors, raw_lock,
    output rock_button, paper_button, scissors_button, stop_signal, locked
  );
endinterface

// File: rtl/rps_input_frontend.sv
// Input front end for the RPS game: synchronizes and debounces four raw
// pushbuttons, then holds a one-hot choice that is frozen by a lock-in
// press. The FSM acts on the debounced value being written on the same
// edge, so a clean press reaches the choice outputs 2+DEBOUNCE_CYCLES
// edges after the raw edge. Bit order everywhere: 0 rock, 1 paper,
// 2 scissors, 3 lock.
module rps_input_frontend #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic            clock,
  input logic            reset_button,
  rps_input_frontend_if.slave bus
);

  localparam logic [7:0] DB_LIMIT_C = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_RELEASE = 3'd3
  } state_t;

  logic [3:0] raw_s;
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] deb_r;
  logic [3:0] deb_nxt_s;
  logic [7:0] cnt_r     [4];
  logic [7:0] cnt_nxt_s [4];
  state_t     state_r;
  logic [2:0] choice_r;
  logic       stop_r;
  logic       locked_r;
  logic       sel_valid_s;
  logic       lock_rise_s;

  // Exactly one of rock/paper/scissors is a selection; none or several is not.
  function automatic logic one_hot3(input logic [2:0] v);
    one_hot3 = (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  assign raw_s = {bus.raw_lock, bus.raw_scissors, bus.raw_paper, bus.raw_rock};

  // Two-flop synchronizer per raw button.
  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: count disagreeing samples, flip level on reaching the limit.
  always_comb begin
    deb_nxt_s = deb_r;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt_s[i] = 8'd0;
      if (sync2_r[i] == deb_r[i]) begin
        cnt_nxt_s[i] = 8'd0;
      end else if ((cnt_r[i] + 8'd1) == DB_LIMIT_C) begin
        deb_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i] = 8'd0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 8'd1;
      end
    end
  end

  // Debounced levels and their stability counters.
  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      deb_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= 8'd0;
      end
    end else begin
      deb_r <= deb_nxt_s;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign sel_valid_s = one_hot3(deb_nxt_s[2:0]);
  assign lock_rise_s = deb_nxt_s[3] & ~deb_r[3];

  // Selection/lock FSM with registered choice, stop pulse and locked flag.
  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      state_r  <= ST_IDLE;
      choice_r <= 3'b000;
      stop_r   <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      stop_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          locked_r <= 1'b0;
          if (sel_valid_s) begin
            choice_r <= deb_nxt_s[2:0];
            state_r  <= ST_ARMED;
          end else begin
            choice_r <= 3'b000;
          end
        end
        ST_ARMED: begin
          // Lock beats a simultaneous selection change: the old choice is frozen.
          if (lock_rise_s) begin
            stop_r   <= 1'b1;
            locked_r <= 1'b1;
            state_r  <= ST_LOCKED;
          end else if (sel_valid_s) begin
            choice_r <= deb_nxt_s[2:0];
          end else begin
            choice_r <= choice_r;
          end
        end
        ST_LOCKED: begin
          locked_r <= 1'b1;
          if (!deb_nxt_s[3]) begin
            state_r <= ST_RELEASE;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        ST_RELEASE: begin
          if (deb_nxt_s == 4'b0000) begin
            choice_r <= 3'b000;
            locked_r <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            locked_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          choice_r <= 3'b000;
          stop_r   <= 1'b0;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rock_button     = choice_r[0];
  assign bus.paper_button    = choice_r[1];
  assign bus.scissors_button = choice_r[2];
  assign bus.stop_signal     = stop_r;
  assign bus.locked          = locked_r;

endmodule

// File: tb/tb_rps_input_frontend.sv
// Bench for rps_input_frontend: directed scenarios followed by random
// button activity, every cycle compared against a behavioural model.
module tb_rps_input_frontend;

  localparam int D = 4;

  logic clock = 1'b0;
  logic reset_button;

  rps_input_frontend_if bus ();

  rps_input_frontend #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset_button (reset_button),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: raw sample history, synchronized sample history,
  // debounced levels, game phase (0 idle, 1 armed, 2 locked, 3 release).
  logic [3:0] raw_hist[$];
  logic [3:0] s_hist[$];
  int         since_flip[4];
  logic [3:0] m_deb;
  int         phase;
  logic [2:0] m_choice;
  logic       m_stop;
  logic       m_locked;

  function automatic void model_reset();
    raw_hist.delete();
    s_hist.delete();
    for (int i = 0; i < 4; i++) since_flip[i] = 1000;
    m_deb    = 4'b0000;
    phase    = 0;
    m_choice = 3'b000;
    m_stop   = 1'b0;
    m_locked = 1'b0;
  endfunction

  // One rising edge of the model. A raw value is seen by the debouncer two
  // edges after it is sampled; a level flips once the last D seen samples
  // all disagree with it and D edges have passed since its previous flip.
  function automatic void model_edge(input logic [3:0] raw_now);
    logic [3:0] s;
    logic [3:0] prev;
    logic       all_diff;
    raw_hist.push_front(raw_now);
    if (raw_hist.size() > 3) void'(raw_hist.pop_back());
    s = (raw_hist.size() == 3) ? raw_hist[2] : 4'b0000;
    s_hist.push_front(s);
    if (s_hist.size() > 300) void'(s_hist.pop_back());
    prev = m_deb;
    for (int i = 0; i < 4; i++) begin
      since_flip[i]++;
      if (since_flip[i] >= D && s_hist.size() >= D) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (s_hist[k][i] == prev[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_deb[i]      = ~prev[i];
          since_flip[i] = 0;
        end
      end
    end
    m_stop = 1'b0;
    if (phase == 0) begin
      if ($countones(m_deb[2:0]) == 1) begin m_choice = m_deb[2:0]; phase = 1; end
    end else if (phase == 1) begin
      if (m_deb[3] && !prev[3]) begin m_stop = 1'b1; m_locked = 1'b1; phase = 2; end
      else if ($countones(m_deb[2:0]) == 1) m_choice = m_deb[2:0];
    end else if (phase == 2) begin
      if (!m_deb[3]) phase = 3;
    end else begin
      if (m_deb == 4'b0000) begin m_choice = 3'b000; m_locked = 1'b0; phase = 0; end
    end
  endfunction

  function automatic logic [7:0] dut_vec();
    return {3'b000, bus.rock_button, bus.paper_button, bus.scissors_button,
            bus.stop_signal, bus.locked};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {3'b000, m_choice[0], m_choice[1], m_choice[2], m_stop, m_locked};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_raw(input logic [3:0] v);
    bus.raw_rock     = v[0];
    bus.raw_paper    = v[1];
    bus.raw_scissors = v[2];
    bus.raw_lock     = v[3];
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clock);
    if (reset_button) model_edge({bus.raw_lock, bus.raw_scissors, bus.raw_paper, bus.raw_rock});
    else model_reset();
    #1;
    chk("cycle_model", dut_vec(), exp_vec());
  endtask

  initial begin
    int stop_cnt;
    int stop_at;
    int found;
    logic [3:0] r;

    reset_button = 1'b0;
    set_raw(4'b0000);
    model_reset();
    repeat (3) step();
    chk("reset_outputs", dut_vec(), 8'h00);
    reset_button = 1'b1;
    repeat (3) step();

    // Clean rock press reaches rock_button exactly 6 edges later.
    set_raw(4'b0001);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) chk("req029_rock_early", {7'd0, bus.rock_button}, 8'h00);
      if (k == 6) chk("req029_rock_edge6", {7'd0, bus.rock_button}, 8'h01);
    end
    chk("req029_stop_low", {7'd0, bus.stop_signal}, 8'h00);

    // Lock press while armed: a single stop pulse 6 edges after the press.
    set_raw(4'b1001);
    stop_cnt = 0;
    stop_at  = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.stop_signal) begin stop_cnt++; stop_at = k; end
    end
    chk("req031_stop_count", 8'(stop_cnt), 8'd1);
    chk("req031_stop_edge", 8'(stop_at), 8'd6);
    chk("req031_rock_locked", {6'd0, bus.rock_button, bus.locked}, 8'h03);
    set_raw(4'b0000);
    repeat (12) step();
    chk("req031_all_clear", dut_vec(), 8'h00);

    // Short paper glitches never produce a paper choice.
    found = 0;
    for (int p = 0; p < 3; p++) begin
      set_raw(4'b0010);
      repeat (2) begin step(); if (bus.paper_button) found = 1; end
      set_raw(4'b0000);
      step();
      if (bus.paper_button) found = 1;
    end
    repeat (10) begin step(); if (bus.paper_button) found = 1; end
    chk("req030_paper_glitch", 8'(found), 8'd0);

    // Rock+scissors together is no selection; dropping scissors selects rock.
    set_raw(4'b0101);
    repeat (10) step();
    chk("req032_no_choice", dut_vec(), 8'h00);
    set_raw(4'b0001);
    repeat (10) step();
    chk("req032_rock", dut_vec(), 8'h10);
    set_raw(4'b0000);
    repeat (10) step();
    chk("req019_hold_on_release", dut_vec(), 8'h10);

    // Reset from ARMED, then lock pressed in IDLE is ignored.
    reset_button = 1'b0;
    #1;
    chk("reset_mid_armed", dut_vec(), 8'h00);
    model_reset();
    step();
    reset_button = 1'b1;
    set_raw(4'b1000);
    stop_cnt = 0;
    repeat (10) begin step(); if (bus.stop_signal) stop_cnt++; end
    chk("req033_idle_lock", 8'(stop_cnt), 8'd0);
    set_raw(4'b0000);
    repeat (8) step();

    // In LOCKED, paper activity does not disturb the frozen rock choice.
    set_raw(4'b0001);
    repeat (8) step();
    set_raw(4'b1001);
    repeat (8) step();
    set_raw(4'b1010);
    repeat (10) step();
    chk("req033_locked_hold", dut_vec(), 8'h11);
    set_raw(4'b0000);
    repeat (12) step();
    chk("req033_back_idle", dut_vec(), 8'h00);

    // Reset during the stop cycle clears outputs at once; no later pulse.
    set_raw(4'b0001);
    repeat (8) step();
    set_raw(4'b1001);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (bus.stop_signal) found = 1;
    end
    chk("req034_stop_seen", 8'(found), 8'd1);
    reset_button = 1'b0;
    #1;
    chk("req034_async_clear", {5'd0, bus.stop_signal, bus.rock_button, bus.locked}, 8'h00);
    model_reset();
    set_raw(4'b0001);
    repeat (3) step();
    reset_button = 1'b1;
    stop_cnt = 0;
    repeat (20) begin step(); if (bus.stop_signal) stop_cnt++; end
    chk("req034_no_pulse", 8'(stop_cnt), 8'd0);
    chk("req028_repress_rock", dut_vec(), 8'h10);

    // Random button activity against the model.
    for (int seg = 0; seg < 300; seg++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r[2:0] = 3'(3'b001 << $urandom_range(0, 2));
      set_raw(r);
      if ($urandom_range(0, 59) == 0) begin
        reset_button = 1'b0;
        #1;
        chk("rand_async_reset", dut_vec(), 8'h00);
        model_reset();
        repeat (2) step();
        reset_button = 1'b1;
      end
      repeat ($urandom_range(1, 10)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
